// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_ctrl
// Description : Successive-approximation ADC sequencer. Drives the analog mux,
//               track/hold switch and trial DAC code, resolves one bit per
//               clock from the comparator, publishes results with a one-cycle
//               valid pulse, and can scan channels round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl #(
    parameter int WIDTH      = 8,
    parameter int NCH        = 4,
    parameter int SAMPLE_CYC = 2,
    localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             scan,
    input  logic [CW-1:0]    ch_sel,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [CW-1:0]    mux_sel,
    output logic             sample,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    data_ch,
    output logic             data_valid
);

    // Down-counter reused for sample timing and as the current trial bit index
    localparam int               c_cnt_w       = 4;
    localparam logic [c_cnt_w-1:0] c_sample_last = c_cnt_w'(SAMPLE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_conv_first  = c_cnt_w'(WIDTH - 1);
    localparam logic [CW-1:0]    c_ch_last     = CW'(NCH - 1);
    localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_msb         = c_one << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [CW-1:0]        r_ch, w_ch_nxt;
    logic [WIDTH-1:0]     r_dac, w_dac_nxt;
    logic [WIDTH-1:0]     r_data, w_data_nxt;
    logic [CW-1:0]        r_data_ch, w_data_ch_nxt;
    logic                 r_sample, w_sample_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_valid, w_valid_nxt;

    // Mask of the bit under trial, and the code with that bit resolved
    logic [WIDTH-1:0]     w_trial_bit;
    logic [WIDTH-1:0]     w_resolved;

    assign w_trial_bit = c_one << r_cnt;
    assign w_resolved  = comp_in ? r_dac : (r_dac & ~w_trial_bit);

    // State and output registers; async reset clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ch      <= '0;
            r_dac     <= '0;
            r_data    <= '0;
            r_data_ch <= '0;
            r_sample  <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ch      <= w_ch_nxt;
            r_dac     <= w_dac_nxt;
            r_data    <= w_data_nxt;
            r_data_ch <= w_data_ch_nxt;
            r_sample  <= w_sample_nxt;
            r_busy    <= w_busy_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    // Next-state and next-output decode; ena low overrides every transition
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ch_nxt      = r_ch;
        w_dac_nxt     = r_dac;
        w_data_nxt    = r_data;
        w_data_ch_nxt = r_data_ch;
        w_sample_nxt  = r_sample;
        w_busy_nxt    = r_busy;
        w_valid_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ch_nxt     = ch_sel;
                    w_state_nxt  = S_SAMPLE;
                    w_cnt_nxt    = c_sample_last;
                    w_sample_nxt = 1'b1;
                    w_dac_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = S_CONVERT;
                    w_cnt_nxt    = c_conv_first;
                    w_sample_nxt = 1'b0;
                    w_dac_nxt    = c_msb;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            S_CONVERT: begin
                if (r_cnt != '0) begin
                    w_dac_nxt = w_resolved | (w_trial_bit >> 1);
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end else begin
                    w_dac_nxt     = w_resolved;
                    w_data_nxt    = w_resolved;
                    w_data_ch_nxt = r_ch;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                if (scan) begin
                    w_ch_nxt     = (r_ch == c_ch_last) ? '0 : r_ch + CW'(1);
                    w_state_nxt  = S_SAMPLE;
                    w_cnt_nxt    = c_sample_last;
                    w_sample_nxt = 1'b1;
                    w_dac_nxt    = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_dac_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort: drop to IDLE without publishing or changing the channel
        if (!ena) begin
            w_state_nxt   = S_IDLE;
            w_ch_nxt      = r_ch;
            w_dac_nxt     = '0;
            w_data_nxt    = r_data;
            w_data_ch_nxt = r_data_ch;
            w_sample_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
            w_valid_nxt   = 1'b0;
        end
    end

    assign dac_code   = r_dac;
    assign mux_sel    = r_ch;
    assign sample     = r_sample;
    assign busy       = r_busy;
    assign data_out   = r_data;
    assign data_ch    = r_data_ch;
    assign data_valid = r_valid;

endmodule
`default_nettype wire

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, conversion resolution in bits (2..12).
REQ-002 SHALL have parameter NCH, default 4, analog input channel count (power of 2, 1..8); CW = max(1, clog2(NCH)).
REQ-003 SHALL have parameter SAMPLE_CYC, default 2, track/hold sampling duration in clocks (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port ena  input  1  enable; low aborts activity.
REQ-007 SHALL have port start  input  1  level-sampled request to convert.
REQ-008 SHALL have port scan  input  1  1 = continuous round-robin over channels.
REQ-009 SHALL have port ch_sel  input  CW  first/only channel to convert.
REQ-010 SHALL have port comp_in  input  1  comparator result; 1 = Vin >= Vdac.
REQ-011 SHALL have port dac_code  output  WIDTH  trial code to capacitive/R-2R DAC.
REQ-012 SHALL have port mux_sel  output  CW  analog mux channel select.
REQ-013 SHALL have port sample  output  1  track/hold switch; 1 = tracking.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port data_out  output  WIDTH  last completed result, held until next DONE.
REQ-016 SHALL have port data_ch  output  CW  channel of data_out.
REQ-017 SHALL have port data_valid  output  1  one-cycle pulse per result.

Function
REQ-018 SHALL implement FSM states IDLE, SAMPLE, CONVERT, DONE; all outputs registered.
REQ-019 In IDLE, an edge with ena=1 and start=1 SHALL load the channel register from ch_sel and enter SAMPLE; start is ignored in every other state.
REQ-020 SAMPLE SHALL last exactly SAMPLE_CYC cycles with sample=1, mux_sel=channel register, dac_code=0.
REQ-021 On entering CONVERT, sample SHALL be 0 and dac_code SHALL be 1 << (WIDTH-1).
REQ-022 CONVERT SHALL last exactly WIDTH cycles; in cycle k (k=0..WIDTH-1), trial bit b=WIDTH-1-k: at the edge, bit b is kept if comp_in=1 else cleared, and bit b-1 (if k<WIDTH-1) is set.
REQ-023 After the last CONVERT edge, state SHALL be DONE for one cycle with data_out=final code, data_ch=channel register, data_valid=1.
REQ-024 Latency: start accepted at edge E0 -> data_valid high in cycle following edge E0+SAMPLE_CYC+WIDTH.
REQ-025 From DONE: if scan=1 and ena=1, channel register SHALL increment modulo NCH (NCH-1 wraps to 0) and FSM enters SAMPLE directly; else FSM enters IDLE.
REQ-026 ena=0 at any edge SHALL force IDLE, sample=0, dac_code=0, data_valid=0; data_out/data_ch retained; no partial result is published.
REQ-027 comp_in SHALL be treated as asynchronous-safe only during CONVERT; its value is ignored in other states.
REQ-028 Back-to-back: in IDLE, start held high SHALL begin a new conversion the edge after DONE returns to IDLE (one idle cycle between results when scan=0).

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, channel register=0, and dac_code, mux_sel, sample, busy, data_out, data_ch, data_valid all to 0, regardless of state.
REQ-030 Release of rst_n SHALL not start a conversion unless start=1 and ena=1 at a subsequent edge.

Verification
REQ-031 Comparator model Vin=0xA5, WIDTH=8, SAMPLE_CYC=2, ch_sel=1, start pulse -> data_valid after 10 cycles, data_out=0xA5, data_ch=1, dac_code trials 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
REQ-032 comp_in tied 1 -> data_out=0xFF; tied 0 -> data_out=0x00.
REQ-033 scan=1, NCH=4, ch_sel=2, Vin per channel {0x10,0x20,0x30,0x40} -> results in order (ch2,0x30),(ch3,0x40),(ch0,0x10),(ch1,0x20), each 11 cycles apart.
REQ-034 start pulsed during CONVERT -> ignored, single data_valid pulse.
REQ-035 rst_n low in CONVERT cycle 4 -> all outputs 0 immediately, no data_valid after release.
REQ-036 ena low in SAMPLE -> IDLE next edge, data_out keeps previous value, no data_valid.
